// File: rtl/tl_pkg.sv
// Shared TileLink-UL encodings and helpers for the SRAM responder.
package tl_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [31:0] expandMask(input logic [3:0] mask);
        expandMask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/tl_sram_array.sv
// DEPTH x 32 word array: byte-masked synchronous write, combinational read.
module tl_sram_array
    import tl_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic [3:0]       wrMask,
    input  logic [31:0]      wrData,
    input  logic [IDX_W-1:0] rdIdx,
    output logic [31:0]      rdData
);

    logic [31:0] mem_r [DEPTH];

    // Byte-lane write; lanes with a clear mask bit keep their old contents
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem_r[wrIdx] <= (mem_r[wrIdx] & ~expandMask(wrMask)) | (wrData & expandMask(wrMask));
        end
    end

    assign rdData = mem_r[rdIdx];

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UL slave endpoint: single outstanding request into a byte-masked
// word memory, one D-channel response per request after LATENCY wait cycles.
module tl_sram_responder
    import tl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [2:0]  io_in_bits_opcode,
    input  logic [31:0] io_in_bits_address,
    input  logic [3:0]  io_in_bits_mask,
    input  logic [31:0] io_in_bits_data,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [2:0]  io_out_bits_opcode,
    output logic [31:0] io_out_bits_data,
    output logic        io_out_bits_denied
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e      state_r;
    state_e      nextState_s;
    logic [3:0]  cnt_r;
    logic [3:0]  nextCnt_s;
    logic        commit_s;
    logic        accept_s;

    logic [2:0]  reqOpcode_r;
    logic [31:0] reqAddr_r;
    logic [3:0]  reqMask_r;
    logic [31:0] reqData_r;

    logic [2:0]  curOpcode_s;
    logic [31:0] curAddr_s;
    logic [3:0]  curMask_s;
    logic [31:0] curData_s;
    logic [31:0] offset_s;
    logic [IDX_W-1:0] idx_s;
    logic        inRange_s;
    logic        aligned_s;
    logic        opLegal_s;
    logic        isGet_s;
    logic        denied_s;
    logic        wrEn_s;
    logic [31:0] rdData_s;
    logic        unusedBits_s;

    logic        outValid_r;
    logic [2:0]  outOpcode_r;
    logic [31:0] outData_r;
    logic        outDenied_r;

    assign accept_s = io_in_valid && (state_r == IDLE);

    // With LATENCY=0 the commit coincides with the accept edge, so decode the live A-channel then
    always_comb begin
        curOpcode_s = reqOpcode_r;
        curAddr_s   = reqAddr_r;
        curMask_s   = reqMask_r;
        curData_s   = reqData_r;
        if (state_r == IDLE) begin
            curOpcode_s = io_in_bits_opcode;
            curAddr_s   = io_in_bits_address;
            curMask_s   = io_in_bits_mask;
            curData_s   = io_in_bits_data;
        end else begin
            curOpcode_s = reqOpcode_r;
            curAddr_s   = reqAddr_r;
            curMask_s   = reqMask_r;
            curData_s   = reqData_r;
        end
    end

    // Offset form of the range check avoids overflow of BASE_ADDR + 4*DEPTH
    assign offset_s     = curAddr_s - BASE_ADDR;
    assign inRange_s    = (curAddr_s >= BASE_ADDR) && ({1'b0, offset_s} < SPAN);
    assign aligned_s    = (curAddr_s[1:0] == 2'd0);
    assign idx_s        = offset_s[IDX_W+1:2];
    assign isGet_s      = (curOpcode_s == GET);
    assign opLegal_s    = isGet_s || (curOpcode_s == PUT_FULL) || (curOpcode_s == PUT_PARTIAL);
    assign denied_s     = !(inRange_s && aligned_s && opLegal_s);
    assign wrEn_s       = commit_s && !isGet_s && !denied_s;
    assign unusedBits_s = ^{offset_s[31:IDX_W+2], offset_s[1:0]};

    tl_sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock  (clock),
        .wrEn   (wrEn_s),
        .wrIdx  (idx_s),
        .wrMask (curMask_s),
        .wrData (curData_s),
        .rdIdx  (idx_s),
        .rdData (rdData_s)
    );

    // State and wait-counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= nextState_s;
            cnt_r   <= nextCnt_s;
        end
    end

    // Next-state logic; commit_s marks the edge that enters RESP
    always_comb begin
        nextState_s = state_r;
        nextCnt_s   = cnt_r;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (io_in_valid) begin
                    if (LATENCY == 0) begin
                        nextState_s = RESP;
                        commit_s    = 1'b1;
                    end else begin
                        nextState_s = WAIT;
                        nextCnt_s   = CNT_INIT;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    nextState_s = RESP;
                    commit_s    = 1'b1;
                end else begin
                    nextCnt_s   = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (io_out_ready) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = RESP;
                end
            end
            default: begin
                nextState_s = IDLE;
                nextCnt_s   = 4'd0;
            end
        endcase
    end

    // Request latch, captured on the accept edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reqOpcode_r <= 3'd0;
            reqAddr_r   <= 32'd0;
            reqMask_r   <= 4'd0;
            reqData_r   <= 32'd0;
        end else if (accept_s) begin
            reqOpcode_r <= io_in_bits_opcode;
            reqAddr_r   <= io_in_bits_address;
            reqMask_r   <= io_in_bits_mask;
            reqData_r   <= io_in_bits_data;
        end else begin
            reqOpcode_r <= reqOpcode_r;
            reqAddr_r   <= reqAddr_r;
            reqMask_r   <= reqMask_r;
            reqData_r   <= reqData_r;
        end
    end

    // Response registers: loaded at commit, held through backpressure, cleared on completion
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outValid_r  <= 1'b0;
            outOpcode_r <= 3'd0;
            outData_r   <= 32'd0;
            outDenied_r <= 1'b0;
        end else if (commit_s) begin
            outValid_r  <= 1'b1;
            outOpcode_r <= isGet_s ? ACCESS_ACK_DATA : ACCESS_ACK;
            outData_r   <= (isGet_s && !denied_s) ? rdData_s : 32'd0;
            outDenied_r <= denied_s;
        end else if ((state_r == RESP) && io_out_ready) begin
            outValid_r  <= 1'b0;
            outOpcode_r <= 3'd0;
            outData_r   <= 32'd0;
            outDenied_r <= 1'b0;
        end else begin
            outValid_r  <= outValid_r;
            outOpcode_r <= outOpcode_r;
            outData_r   <= outData_r;
            outDenied_r <= outDenied_r;
        end
    end

    assign io_in_ready        = (state_r == IDLE);
    assign io_out_valid       = outValid_r;
    assign io_out_bits_opcode = outOpcode_r;
    assign io_out_bits_data   = outData_r;
    assign io_out_bits_denied = outDenied_r;

endmodule
